imem_loader: RTL
================

# imem_loader

Upstream feeder for the 64-entry shift-register instruction memory. Accepts a byte stream over a valid/ready handshake, assembles bytes into 16-bit words MSB-first, and drives the memory's `shift_enable`/`new_value` pair with one single-cycle shift pulse per word. After exactly `DEPTH` words it stops and holds `done`, so a complete program image lands in the memory in stream order (first word ends at entry `DEPTH-1`, last word at entry 0).

## Interface
Parameters:
- `DEPTH`, 64: words per load; must match memory depth; range 2..127.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE or DONE.
- `abort`  in  1  cancel an in-progress load; returns to IDLE.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `shift_enable`  out  1  single-cycle pulse to the memory.
- `new_value`  out  16  assembled word; valid while `shift_enable`=1.
- `word_count`  out  7  words shifted in the current load.
- `busy`  out  1  load in progress (any state except IDLE/DONE).
- `done`  out  1  full image loaded; held until next `start` or reset.
- `err`  out  1  checksum mismatch (see Configuration); 0 when the feature is compiled out.

## Operation
- States: IDLE, HI (await high byte), LO (await low byte), SHIFT, CHK (checksum byte, only with macro), DONE.
- Byte accepted iff `byte_valid && byte_ready` at a rising edge; `byte_ready`=1 only in HI, LO, CHK.
- IDLE/DONE + `start` -> HI; clears `word_count`, `done`, `err`, and the checksum accumulator.
- HI: on accept, `byte_in` -> `new_value[15:8]`; -> LO.
- LO: on accept, `byte_in` -> `new_value[7:0]`; -> SHIFT.
- SHIFT: `shift_enable`=1 for this one cycle; `word_count` increments at the end of the cycle; if incremented count == `DEPTH` -> DONE (or CHK with macro), else -> HI.
- DONE: `done`=1, `busy`=0; `start` is the only exit.
- `new_value` holds its last value outside SHIFT; upper byte changes only on HI accept.
- `abort` (any busy state) -> IDLE next edge; no `shift_enable` that cycle, even from SHIFT; partial word discarded; `word_count` retains its value; `done`=0. Any words already shifted stay in the memory.
- `start` while busy: ignored. `start` and `abort` together in IDLE: `abort` wins (stay IDLE).
- `byte_valid` outside HI/LO/CHK: ignored; the source must hold the byte until ready.

## Timing
- Reset values: state IDLE; `byte_ready`, `shift_enable`, `busy`, `done`, `err` = 0; `new_value` = 16'h0000; `word_count` = 0.
- Reset mid-load aborts immediately and asynchronously; no shift pulse is issued.
- Minimum 3 cycles per word (HI, LO, SHIFT) with `byte_valid` held high; a full load takes 3·`DEPTH` cycles after the `start` edge, +1 with checksum.
- `shift_enable` is never high on two consecutive cycles.
- `done` rises on the edge after the final SHIFT cycle (or after the CHK accept).
- Stalls (`byte_valid`=0) in HI/LO/CHK extend the load without limit; no timeout.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: XOR of every accepted data byte is accumulated. After the `DEPTH`th SHIFT -> CHK; one extra byte is accepted; `err` = (byte != accumulator), registered with `done` and held until next `start`/reset. Words are already shifted regardless of `err`.
- Not defined: no CHK state, no accumulator; `err` tied to 0; SHIFT goes directly to DONE.

## Test plan
- Reset: assert `rst` mid-load after 5 words -> all outputs at reset values immediately, no further `shift_enable`.
- Full load, `byte_valid` held: start, stream bytes 0x00..0x7F -> 64 pulses with `new_value` 0x0001, 0x0203, …, 0x7E7F; pulses spaced 3 cycles; `done`=1 and `word_count`=64 after pulse 64.
- Backpressure: random `byte_valid` gaps -> same word sequence; no byte dropped or duplicated; `byte_ready` low in SHIFT.
- Abort: abort in LO of word 10 -> IDLE next cycle, exactly 9 pulses total, `word_count`=9, `done`=0; a new `start` restarts with `word_count`=0.
- Start while busy: pulse `start` during word 3 -> ignored, load completes normally with 64 pulses.
- Checksum (macro on): full load then correct XOR byte -> `done`=1, `err`=0; repeat with byte XOR 0x01 -> `done`=1, `err`=1, 64 pulses in both cases.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream feeder for the shift-register instruction memory: packs bytes MSB-first into
// 16-bit words and pulses shift_enable once per word. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        shift_enable,
  output logic [15:0] new_value,
  output logic [6:0]  word_count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_SHIFT,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  localparam logic [6:0] LAST_COUNT = 7'(DEPTH);

  state_t state;
  logic   shift_q;
  logic   accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`else
  assign err = 1'b0;
`endif

  assign accept = byte_valid && byte_ready;

  // The registered pulse is gated by abort so an abort during SHIFT never reaches the memory.
  assign shift_enable = shift_q && !abort;

  // NOTE: all state and registered outputs use non-blocking assignments so every read in this
  // block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shift_q    <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      new_value  <= 16'h0000;
      word_count <= 7'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err        <= 1'b0;
      csum       <= 8'h00;
`endif
    end else if (busy && abort) begin
      // Partial word is dropped; word_count keeps the number of words already shifted.
      state      <= S_IDLE;
      shift_q    <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !(state == S_IDLE && abort)) begin
            state      <= S_HI;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            word_count <= 7'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err        <= 1'b0;
            csum       <= 8'h00;
`endif
          end
        end
        S_HI: begin
          if (accept) begin
            new_value[15:8] <= byte_in;
            state           <= S_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum            <= csum ^ byte_in;
`endif
          end
        end
        S_LO: begin
          if (accept) begin
            new_value[7:0] <= byte_in;
            state          <= S_SHIFT;
            byte_ready     <= 1'b0;
            shift_q        <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum           <= csum ^ byte_in;
`endif
          end
        end
        S_SHIFT: begin
          shift_q    <= 1'b0;
          word_count <= word_count + 7'd1;
          if (word_count + 7'd1 == LAST_COUNT) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= S_CHK;
            byte_ready <= 1'b1;
`else
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
`endif
          end else begin
            state      <= S_HI;
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            err        <= (byte_in != csum);
            state      <= S_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          shift_q    <= 1'b0;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
